char_sequencer: RTL and testbench

- Parametrised character-clock sequencer, successor to the fixed 18-cycle MDA sequencer.
- Divides the pixel clock into a per-character slot sequence that produces VRAM/charrom/pipeline strobes and the CRTC clock enable.
- Adds a runtime-selectable second period (e.g. 70 Hz / alternate timing) that switches only at character boundaries.
- Adds a registered ISA request/grant arbiter, so a granted ISA operation always finishes at least ISA_GUARD cycles before the next VRAM read slot.

---
 rtl/char_sequencer_pkg.sv | 12 +
 rtl/char_sequencer_isa_arb.sv | 69 ++++++
 rtl/char_sequencer.sv | 112 +++++++++++
 tb/tb_char_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/char_sequencer_pkg.sv
// Shared constants and arbiter state encoding for the character-clock sequencer.
package char_sequencer_pkg;
  localparam int SLOT_CHAR_OFS = 2;
  localparam int SLOT_ATT_OFS  = 3;
  localparam int SLOT_LEN      = 4;
  localparam int MDA_PERIOD    = 18;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACTIVE = 1'b1
  } arb_state_e;
endpackage

// File: rtl/char_sequencer_isa_arb.sv
// ISA request/grant arbiter: grants only when a whole op fits before the
// guard band at the end of the current character.
module isa_slot_arbiter
  import char_sequencer_pkg::*;
#(
  parameter int CW            = 5,
  parameter int ISA_WIN_LO    = 6,
  parameter int ISA_GUARD     = 2,
  parameter int ISA_OP_CYCLES = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [CW-1:0] seq_i,
  input  logic [CW:0]   period_i,
  input  logic          isa_req_i,
  output logic          isa_grant_o,
  output logic          isa_busy_o
);
  localparam int PW = CW + 1;
  localparam int OW = $clog2(ISA_OP_CYCLES + 1);
  localparam logic [PW-1:0] WLO      = PW'(ISA_WIN_LO);
  localparam logic [PW-1:0] OPC      = PW'(ISA_OP_CYCLES);
  localparam logic [PW-1:0] GRD      = PW'(ISA_GUARD);
  localparam logic [OW-1:0] OPC_LAST = OW'(ISA_OP_CYCLES - 1);

  arb_state_e    state_q;
  logic [OW-1:0] opcnt_q;
  logic          grant_q;
  logic          busy_q;
  logic [PW-1:0] seq_ext;
  logic          eligible;

  assign seq_ext  = {1'b0, seq_i};
  // Period cannot change before the wrap, so an op that fits now cannot overlap the next read slot.
  assign eligible = isa_req_i && (seq_ext >= WLO) && ((seq_ext + OPC) <= (period_i - GRD));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      opcnt_q <= '0;
      grant_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      grant_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (eligible) begin
            state_q <= ARB_ACTIVE;
            grant_q <= 1'b1;
            busy_q  <= 1'b1;
            opcnt_q <= OPC_LAST;
          end
        end
        ARB_ACTIVE: begin
          if (opcnt_q != '0) begin
            opcnt_q <= opcnt_q - 1'b1;
          end else begin
            state_q <= ARB_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign isa_grant_o = grant_q;
  assign isa_busy_o  = busy_q;
endmodule

// File: rtl/char_sequencer.sv
// Character-clock sequencer: per-character slot counter with runtime period
// select (latched at wrap), slot strobe decodes and the ISA slot arbiter.
module char_sequencer
  import char_sequencer_pkg::*;
#(
  parameter int CW            = 5,
  parameter int PERIOD_A      = MDA_PERIOD,
  parameter int PERIOD_B      = MDA_PERIOD,
  parameter int SLOT_BASE     = 1,
  parameter int ISA_WIN_LO    = 6,
  parameter int ISA_GUARD     = 2,
  parameter int ISA_OP_CYCLES = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          mode_sel,
  input  logic          isa_req,
  output logic [CW-1:0] clk_seq,
  output logic          crtc_clk,
  output logic          vram_read,
  output logic          vram_read_a0,
  output logic          vram_read_char,
  output logic          vram_read_att,
  output logic          charrom_read,
  output logic          disp_pipeline,
  output logic          isa_op_enable,
  output logic          isa_grant,
  output logic          isa_busy
);
  localparam int PW = CW + 1;
  localparam logic [PW-1:0] PA     = PW'(PERIOD_A);
  localparam logic [PW-1:0] PB     = PW'(PERIOD_B);
  localparam logic [PW-1:0] GRD    = PW'(ISA_GUARD);
  localparam logic [CW-1:0] SL_RD0 = CW'(SLOT_BASE);
  localparam logic [CW-1:0] SL_CHR = CW'(SLOT_BASE + SLOT_CHAR_OFS);
  localparam logic [CW-1:0] SL_ATT = CW'(SLOT_BASE + SLOT_ATT_OFS);
  localparam logic [CW-1:0] SL_END = CW'(SLOT_BASE + SLOT_LEN - 1);
  localparam logic [CW-1:0] WLO    = CW'(ISA_WIN_LO);

  if (!(SLOT_BASE + 3 < ISA_WIN_LO)) begin : g_chk_slot
    $error("char_sequencer: VRAM read slot overlaps ISA window");
  end
  if ((ISA_WIN_LO + ISA_OP_CYCLES > PERIOD_A - ISA_GUARD) ||
      (ISA_WIN_LO + ISA_OP_CYCLES > PERIOD_B - ISA_GUARD)) begin : g_chk_fit
    $error("char_sequencer: ISA op does not fit in the shorter period");
  end
  if (ISA_GUARD < 1) begin : g_chk_guard
    $error("char_sequencer: ISA_GUARD must be at least 1");
  end
  if ((PERIOD_A > (1 << CW)) || (PERIOD_B > (1 << CW))) begin : g_chk_cw
    $error("char_sequencer: period exceeds clk_seq range");
  end

  logic [CW-1:0] seq_q, seq_d;
  logic          crtc_q, crtc_d;
  logic          mode_q, mode_d;
  logic [PW-1:0] period;
  logic [PW-1:0] seq_ext;
  logic          wrap;

  assign period  = mode_q ? PB : PA;
  assign seq_ext = {1'b0, seq_q};
  assign wrap    = (seq_ext == (period - 1'b1));

  always_comb begin
    seq_d  = seq_q + 1'b1;
    crtc_d = 1'b0;
    mode_d = mode_q;
    if (wrap) begin
      seq_d  = '0;
      crtc_d = 1'b1;
      mode_d = mode_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_q  <= '0;
      crtc_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      seq_q  <= seq_d;
      crtc_q <= crtc_d;
      mode_q <= mode_d;
    end
  end

  assign clk_seq        = seq_q;
  assign crtc_clk       = crtc_q;
  assign vram_read      = (seq_q >= SL_RD0) && (seq_q <= SL_END);
  assign vram_read_a0   = (seq_q == SL_CHR);
  assign vram_read_char = (seq_q == SL_CHR);
  assign vram_read_att  = (seq_q == SL_ATT);
  assign charrom_read   = (seq_q == SL_RD0);
  assign disp_pipeline  = (seq_q == SL_ATT);
  assign isa_op_enable  = (seq_q >= WLO) && (seq_ext < (period - GRD));

  isa_slot_arbiter #(
    .CW            (CW),
    .ISA_WIN_LO    (ISA_WIN_LO),
    .ISA_GUARD     (ISA_GUARD),
    .ISA_OP_CYCLES (ISA_OP_CYCLES)
  ) u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .seq_i       (seq_q),
    .period_i    (period),
    .isa_req_i   (isa_req),
    .isa_grant_o (isa_grant),
    .isa_busy_o  (isa_busy)
  );
endmodule

// File: tb/tb_char_sequencer.sv
// Directed bench for char_sequencer with PERIOD_B=20 as the alternate timing.
module tb_char_sequencer;
  logic       clk;
  logic       reset_n;
  logic       mode_sel;
  logic       isa_req;
  logic [4:0] clk_seq;
  logic       crtc_clk, vram_read, vram_read_a0, vram_read_char, vram_read_att;
  logic       charrom_read, disp_pipeline, isa_op_enable, isa_grant, isa_busy;

  int total = 0;
  int bad   = 0;

  char_sequencer #(.CW(5), .PERIOD_A(18), .PERIOD_B(20)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mode_sel       (mode_sel),
    .isa_req        (isa_req),
    .clk_seq        (clk_seq),
    .crtc_clk       (crtc_clk),
    .vram_read      (vram_read),
    .vram_read_a0   (vram_read_a0),
    .vram_read_char (vram_read_char),
    .vram_read_att  (vram_read_att),
    .charrom_read   (charrom_read),
    .disp_pipeline  (disp_pipeline),
    .isa_op_enable  (isa_op_enable),
    .isa_grant      (isa_grant),
    .isa_busy       (isa_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_seq(input int target);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((int'(clk_seq) != target) && (n < 64));
    chk("wait_seq", 32'(clk_seq), 32'(target));
  endtask

  task automatic chk_strobes(input int s, input int p);
    chk("vram_read",      32'(vram_read),      32'(s >= 1 && s <= 4));
    chk("charrom_read",   32'(charrom_read),   32'(s == 1));
    chk("vram_read_a0",   32'(vram_read_a0),   32'(s == 3));
    chk("vram_read_char", 32'(vram_read_char), 32'(s == 3));
    chk("vram_read_att",  32'(vram_read_att),  32'(s == 4));
    chk("disp_pipeline",  32'(disp_pipeline),  32'(s == 4));
    chk("isa_op_enable",  32'(isa_op_enable),  32'(s >= 6 && s < p - 2));
  endtask

  initial begin
    int s;
    int p;
    reset_n  = 1'b0;
    mode_sel = 1'b0;
    isa_req  = 1'b0;
    tick();
    tick();
    chk("rst_seq",   32'(clk_seq),   0);
    chk("rst_crtc",  32'(crtc_clk),  0);
    chk("rst_grant", 32'(isa_grant), 0);
    chk("rst_busy",  32'(isa_busy),  0);
    chk_strobes(0, 18);
    reset_n = 1'b1;

    // Two characters at period A: counter, crtc pulse and all decodes.
    for (int i = 1; i <= 36; i++) begin
      tick();
      s = i % 18;
      chk("a_seq",  32'(clk_seq),  32'(s));
      chk("a_crtc", 32'(crtc_clk), 32'(s == 0));
      chk_strobes(s, 18);
    end

    // Request raised at seq 2, dropped once granted.
    wait_seq(2);
    isa_req = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      s = 2 + j;
      chk("req2_grant", 32'(isa_grant), 32'(s == 7));
      chk("req2_busy",  32'(isa_busy),  32'(s >= 7 && s <= 9));
      if (s == 7) isa_req = 1'b0;
    end
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("req2_nogrant", 32'(isa_grant), 0);
      chk("req2_nobusy",  32'(isa_busy),  0);
    end

    // Request held for two characters: grants at 7 and 11 only.
    wait_seq(0);
    isa_req = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      tick();
      s = k % 18;
      chk("hold_grant", 32'(isa_grant), 32'(s == 7 || s == 11));
      chk("hold_busy",  32'(isa_busy),  32'((s >= 7 && s <= 9) || (s >= 11 && s <= 13)));
    end
    isa_req = 1'b0;

    // Request raised too late: granted in the next character.
    wait_seq(14);
    isa_req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("late_seq",   32'(clk_seq),   32'((14 + i) % 18));
      chk("late_grant", 32'(isa_grant), 32'(i == 11));
      chk("late_busy",  32'(isa_busy),  32'(i >= 11 && i <= 13));
      if (i == 11) isa_req = 1'b0;
    end

    // Mode switch mid-character takes effect only after the wrap.
    wait_seq(5);
    mode_sel = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      tick();
      s = (i <= 13) ? (5 + i) % 18 : (i - 13) % 20;
      p = (i < 13) ? 18 : 20;
      chk("mb_seq",  32'(clk_seq),  32'(s));
      chk("mb_crtc", 32'(crtc_clk), 32'(s == 0));
      chk_strobes(s, p);
    end
    mode_sel = 1'b0;
    for (int i = 1; i <= 38; i++) begin
      tick();
      s = (i <= 20) ? i % 20 : (i - 20) % 18;
      chk("ma_seq",  32'(clk_seq),  32'(s));
      chk("ma_crtc", 32'(crtc_clk), 32'(s == 0));
    end

    // Held request with random mode toggles over ~1000 characters.
    isa_req = 1'b1;
    for (int c = 0; c < 19000; c++) begin
      mode_sel = 1'($urandom_range(0, 1));
      tick();
      chk("busy_vs_read", 32'(isa_busy && vram_read), 0);
      chk("grant_pos", 32'(isa_grant && !(clk_seq == 7 || clk_seq == 11 || clk_seq == 15)), 0);
    end
    isa_req  = 1'b0;
    mode_sel = 1'b0;
    wait_seq(0);
    wait_seq(0);

    // Async reset during an ISA op.
    wait_seq(2);
    isa_req = 1'b1;
    wait_seq(8);
    chk("pre_rst_busy", 32'(isa_busy), 1);
    reset_n = 1'b0;
    isa_req = 1'b0;
    #1;
    chk("arst_busy",  32'(isa_busy),  0);
    chk("arst_grant", 32'(isa_grant), 0);
    chk("arst_crtc",  32'(crtc_clk),  0);
    chk("arst_seq",   32'(clk_seq),   0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      tick();
      chk("post_seq",   32'(clk_seq),   32'(i % 18));
      chk("post_crtc",  32'(crtc_clk),  32'(i == 18));
      chk("post_grant", 32'(isa_grant), 0);
      chk("post_busy",  32'(isa_busy),  0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
